// File: rtl/exe_stage_reg_if.sv
// rtl/exe_stage_reg_if.sv - ID/EX operand bundle in, EX/MEM pipeline bundle out
//
// Purpose: groups every signal of the execute stage except clk/rst_n.
//   master: the upstream driver (decode/Val2 side plus the stage control
//           freeze/flush) and observer of the EX/MEM register.
//   slave : the execute stage itself.
// Signals:
//   valid_in, freeze, flush        stage control
//   exe_cmd, s_bit                 ALU opcode and status-update request
//   val1, val2, st_val_in          operands and store data
//   dest_in, wb_en_in,
//   mem_r_en_in, mem_w_en_in       control carried into EX/MEM
//   status_out                     current {N,Z,C,V}
//   valid_out, alu_res, st_val,
//   dest, wb_en, mem_r_en,
//   mem_w_en                       registered EX/MEM outputs
interface exe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic              valid_in;
  logic              freeze;
  logic              flush;
  logic [3:0]        exe_cmd;
  logic              s_bit;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] st_val_in;
  logic [REG_AW-1:0] dest_in;
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;

  logic [3:0]        status_out;
  logic              valid_out;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] st_val;
  logic [REG_AW-1:0] dest;
  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;

  modport master (
    output valid_in, freeze, flush, exe_cmd, s_bit, val1, val2, st_val_in,
           dest_in, wb_en_in, mem_r_en_in, mem_w_en_in,
    input  status_out, valid_out, alu_res, st_val, dest, wb_en, mem_r_en,
           mem_w_en
  );

  modport slave (
    input  valid_in, freeze, flush, exe_cmd, s_bit, val1, val2, st_val_in,
           dest_in, wb_en_in, mem_r_en_in, mem_w_en_in,
    output status_out, valid_out, alu_res, st_val, dest, wb_en, mem_r_en,
           mem_w_en
  );
endinterface

// File: rtl/exe_stage_reg.sv
// rtl/exe_stage_reg.sv - execute stage: ALU, NZCV status register, EX/MEM register
//
// Purpose: performs the exe_cmd ALU operation on val1/val2, keeps the NZCV
//   status register and registers result plus control into EX/MEM.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears all outputs and status
//   bus    exe_stage_reg_if.slave (operands/control in, EX/MEM out)
module exe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  exe_stage_reg_if.slave    bus
);

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;

  localparam int MSB = DATA_W - 1;

  logic [3:0]        status_q;
  logic              c_in;
  logic [DATA_W:0]   ext1;
  logic [DATA_W:0]   ext2;
  logic [DATA_W:0]   cin_ext;
  logic [DATA_W:0]   bin_ext;
  logic [DATA_W:0]   wide;
  logic [DATA_W-1:0] res;
  logic              c_new;
  logic              v_new;
  logic              load_instr;
  logic              update_status;

  // Carry-in comes from the registered flags, never from this cycle's result.
  assign c_in    = status_q[1];
  assign ext1    = {1'b0, bus.val1};
  assign ext2    = {1'b0, bus.val2};
  assign cin_ext = {{DATA_W{1'b0}}, c_in};
  assign bin_ext = {{DATA_W{1'b0}}, ~c_in};

  always_comb begin
    wide  = '0;
    res   = '0;
    c_new = status_q[1];
    v_new = status_q[0];
    case (bus.exe_cmd)
      OP_MOV: res = bus.val2;
      OP_MVN: res = ~bus.val2;
      OP_ADD, OP_ADC: begin
        wide  = ext1 + ext2 + ((bus.exe_cmd == OP_ADC) ? cin_ext : '0);
        res   = wide[MSB:0];
        c_new = wide[DATA_W];
        v_new = (bus.val1[MSB] == bus.val2[MSB]) && (res[MSB] != bus.val1[MSB]);
      end
      OP_SUB, OP_SBC: begin
        // Bit DATA_W of the extended difference is the unsigned borrow.
        wide  = ext1 - ext2 - ((bus.exe_cmd == OP_SBC) ? bin_ext : '0);
        res   = wide[MSB:0];
        c_new = ~wide[DATA_W];
        v_new = (bus.val1[MSB] != bus.val2[MSB]) && (res[MSB] != bus.val1[MSB]);
      end
      OP_AND: res = bus.val1 & bus.val2;
      OP_ORR: res = bus.val1 | bus.val2;
      OP_EOR: res = bus.val1 ^ bus.val2;
      default: res = '0;
    endcase
  end

  assign load_instr    = bus.valid_in && !bus.flush;
  assign update_status = load_instr && bus.s_bit && !bus.freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 4'b0000;
    end else if (update_status) begin
      status_q <= {res[MSB], (res == '0), c_new, v_new};
    end
  end

  // Freeze outranks flush; a flushed or invalid slot becomes an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_out <= 1'b0;
      bus.alu_res   <= '0;
      bus.st_val    <= '0;
      bus.dest      <= '0;
      bus.wb_en     <= 1'b0;
      bus.mem_r_en  <= 1'b0;
      bus.mem_w_en  <= 1'b0;
    end else if (!bus.freeze) begin
      if (load_instr) begin
        bus.valid_out <= 1'b1;
        bus.alu_res   <= res;
        bus.st_val    <= bus.st_val_in;
        bus.dest      <= bus.dest_in;
        bus.wb_en     <= bus.wb_en_in;
        bus.mem_r_en  <= bus.mem_r_en_in;
        bus.mem_w_en  <= bus.mem_w_en_in;
      end else begin
        bus.valid_out <= 1'b0;
        bus.alu_res   <= '0;
        bus.st_val    <= '0;
        bus.dest      <= '0;
        bus.wb_en     <= 1'b0;
        bus.mem_r_en  <= 1'b0;
        bus.mem_w_en  <= 1'b0;
      end
    end
  end

  assign bus.status_out = status_q;

endmodule

// File: tb/tb_exe_stage_reg.sv
// tb/tb_exe_stage_reg.sv - scoreboard bench for exe_stage_reg
module tb_exe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] res;
    logic [31:0] st;
    logic [3:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  status;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exe_stage_reg_if #(.DATA_W(32), .REG_AW(4)) bus ();

  exe_stage_reg #(.DATA_W(32), .REG_AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  obs_t        sb[$];
  obs_t        m_out;
  logic [3:0]  m_status;
  int          n_cmp  = 0;
  int          n_fail = 0;

  function automatic obs_t dut_obs();
    obs_t o;
    o = {bus.valid_out, bus.alu_res, bus.st_val, bus.dest, bus.wb_en,
         bus.mem_r_en, bus.mem_w_en, bus.status_out};
    return o;
  endfunction

  // Reference ALU: flags from 64-bit unsigned/signed arithmetic.
  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                  input logic [31:0] b, input logic [3:0] st,
                                  output logic [31:0] r, output logic [3:0] nzcv);
    logic        c, v;
    logic [63:0] ua, ub, k;
    longint      sr;
    c  = st[1];
    v  = st[0];
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = 32'h0;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd2, 4'd3: begin
        k  = (cmd == 4'd3 && st[1]) ? 64'd1 : 64'd0;
        ua = ua + ub + k;
        r  = ua[31:0];
        c  = ua[32];
        sr = $signed({{32{a[31]}}, a}) + $signed({{32{b[31]}}, b}) + $signed(k);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        k  = (cmd == 4'd5 && !st[1]) ? 64'd1 : 64'd0;
        c  = (ua >= ub + k);
        r  = a - b - k[31:0];
        sr = $signed({{32{a[31]}}, a}) - $signed({{32{b[31]}}, b}) - $signed(k);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      default: r = 32'h0;
    endcase
    nzcv = {r[31], (r == 32'h0), c, v};
  endfunction

  task automatic drive(input logic v, input logic fr, input logic fl,
                       input logic [3:0] cmd, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] stv, input logic [3:0] d,
                       input logic wb, input logic mr, input logic mw);
    logic [31:0] r;
    logic [3:0]  nzcv;
    obs_t        nx;
    bus.valid_in = v;    bus.freeze = fr;      bus.flush = fl;
    bus.exe_cmd = cmd;   bus.s_bit = s;        bus.val1 = a;
    bus.val2 = b;        bus.st_val_in = stv;  bus.dest_in = d;
    bus.wb_en_in = wb;   bus.mem_r_en_in = mr; bus.mem_w_en_in = mw;
    ref_alu(cmd, a, b, m_status, r, nzcv);
    if (fr) begin
      nx = m_out;
    end else if (fl || !v) begin
      nx = '0;
    end else begin
      nx = {1'b1, r, stv, d, wb, mr, mw, 4'b0000};
      if (s) m_status = nzcv;
    end
    nx.status = m_status;
    m_out = nx;
    sb.push_back(nx);
  endtask

  task automatic model_reset();
    m_out = '0;
    m_status = 4'b0000;
    sb.delete();
  endtask

  task automatic test_reset();
    obs_t o, e;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk); #1;
    o = dut_obs(); n_cmp++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_initial: got %h want 0", o); end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 32'h8000_0000, 32'h8000_0001, 32'h1234, 4'h7, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = dut_obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL reset_preload: got %h want %h", o, e); end
    #3 rst_n = 1'b0;
    #1;
    o = dut_obs(); n_cmp++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_async: got %h want 0", o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_add_flags();
    obs_t o, e;
    drive(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'h3, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = dut_obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL add_flags: got %h want %h", o, e); end
    n_cmp++;
    if (bus.alu_res !== 32'h0 || bus.status_out !== 4'b0110) begin
      n_fail++;
      $display("FAIL add_flags_const: got res=%h nzcv=%b want res=0 nzcv=0110", bus.alu_res, bus.status_out);
    end
  endtask

  task automatic test_sub_adc();
    obs_t o, e;
    drive(1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 32'h8000_0000, 32'h1, 32'h0, 4'h1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = dut_obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL sub_ovf: got %h want %h", o, e); end
    n_cmp++;
    if (bus.alu_res !== 32'h7FFF_FFFF || bus.status_out !== 4'b0011) begin
      n_fail++;
      $display("FAIL sub_ovf_const: got res=%h nzcv=%b want res=7fffffff nzcv=0011", bus.alu_res, bus.status_out);
    end
    drive(1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 32'd5, 32'd3, 32'h0, 4'h2, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = dut_obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL adc_chain: got %h want %h", o, e); end
    n_cmp++;
    if (bus.alu_res !== 32'd9) begin
      n_fail++; $display("FAIL adc_chain_const: got %h want 9", bus.alu_res);
    end
  endtask

  task automatic test_logic_preserve();
    obs_t o, e;
    drive(1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 32'hF0, 32'h0F, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = dut_obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL and_flags: got %h want %h", o, e); end
    n_cmp++;
    if (bus.alu_res !== 32'h0 || bus.status_out !== 4'b0111) begin
      n_fail++;
      $display("FAIL and_flags_const: got res=%h nzcv=%b want res=0 nzcv=0111", bus.alu_res, bus.status_out);
    end
  endtask

  task automatic test_freeze_flush();
    obs_t o, e;
    drive(1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, 32'hA0, 32'h05, 32'h55, 4'h9, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    e = sb.pop_front(); o = dut_obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL ff_preload: got %h want %h", o, e); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 32'h0, 32'h1, 32'h0, 4'h4, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
      e = sb.pop_front(); o = dut_obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL freeze_flush_hold%0d: got %h want %h", i, o, e); end
    end
    drive(1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 32'h0, 32'h1, 32'h77, 4'h4, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    e = sb.pop_front(); o = dut_obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL flush_bubble: got %h want %h", o, e); end
    n_cmp++;
    if (bus.valid_out !== 1'b0 || bus.wb_en !== 1'b0 || bus.mem_w_en !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ctrl: got v=%b wb=%b mw=%b want 0 0 0", bus.valid_out, bus.wb_en, bus.mem_w_en);
    end
  endtask

  task automatic test_store();
    obs_t o, e;
    logic [3:0] st_before;
    st_before = m_status;
    drive(1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h400, 32'h8, 32'hDEAD, 4'h5, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    e = sb.pop_front(); o = dut_obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL store: got %h want %h", o, e); end
    n_cmp++;
    if (bus.alu_res !== 32'h408 || bus.st_val !== 32'hDEAD || bus.mem_w_en !== 1'b1 ||
        bus.status_out !== st_before) begin
      n_fail++;
      $display("FAIL store_const: got res=%h st=%h mw=%b nzcv=%b want 408 dead 1 %b",
               bus.alu_res, bus.st_val, bus.mem_w_en, bus.status_out, st_before);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    drive(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h2, 32'h0, 4'h1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = dut_obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL b2b_add: got %h want %h", o, e); end
    drive(1'b1, 1'b0, 1'b0, 4'b0011, 1'b1, 32'h0, 32'h0, 32'h0, 4'h2, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = dut_obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL b2b_adc: got %h want %h", o, e); end
    n_cmp++;
    if (bus.alu_res !== 32'h1) begin
      n_fail++; $display("FAIL b2b_adc_const: got %h want 1", bus.alu_res);
    end
    drive(1'b1, 1'b0, 1'b0, 4'b0101, 1'b1, 32'h10, 32'h10, 32'h0, 4'h3, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = dut_obs(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL b2b_sbc: got %h want %h", o, e); end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [31:0] a, b;
    for (int i = 0; i < 80; i++) begin
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 1, 31'h0};
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h1;
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), a, b, $urandom(),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      e = sb.pop_front(); o = dut_obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL random%0d: got %h want %h", i, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_add_flags();
    test_sub_adc();
    test_logic_preserve();
    test_freeze_flush();
    test_store();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
